// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pin arbiter.
// Direction encoding matches the wr request bit: 1 drives the pins, 0 samples them.
package uio_arb_pkg;

    localparam int   LEN_W  = 4;
    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_XFER = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uio_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright, and on a tie
// the requester that was not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_idx,
    output logic [1:0] winner,
    output logic       any
);

    always_comb begin
        winner = req;
        if (req == 2'b11) begin
            winner = last_idx ? 2'b01 : 2'b10;
        end
    end

    assign any = |req;

endmodule

// File: rtl/uio_bus_arbiter.sv
// Shares the eight uio pins between two burst requesters, inserting tristate
// turnaround cycles whenever the pin direction has to flip.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int TURN_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [1:0]       wr,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic [7:0]       wdata0,
    input  logic [7:0]       wdata1,
    input  logic [7:0]       uio_in,
    output logic [1:0]       gnt,
    output logic [1:0]       wbeat,
    output logic [1:0]       rvalid,
    output logic [7:0]       rdata,
    output logic [1:0]       done,
    output logic [7:0]       uio_out,
    output logic [7:0]       uio_oe,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    // Handshake: a requester holds req until it sees done; grant is implied by
    // gnt, and req/wr/len are only looked at in IDLE when the winner is picked.
    localparam logic [1:0] TURN_LAST = 2'(TURN_CYCLES - 1);

    arb_state_t       state;
    logic             bus_dir;
    logic             rr_ptr;
    logic             cur_idx;
    logic             cur_wr;
    logic [LEN_W-1:0] cur_len;
    logic [LEN_W-1:0] beat_cnt;
    logic [1:0]       turn_cnt;

    logic [1:0]       win;
    logic             win_any;
    logic             win_idx;
    logic             sel_wr;
    logic [LEN_W-1:0] sel_len;
    logic [1:0]       cur_oh;
    logic [7:0]       cur_wdata;
    logic             last_beat;

    // rr_ptr names the requester preferred next, so the last served is its complement.
    rr_arb2 u_rr (
        .req      (req),
        .last_idx (~rr_ptr),
        .winner   (win),
        .any      (win_any)
    );

    assign win_idx   = win[1] & ~win[0];
    assign sel_wr    = wr[win_idx];
    assign sel_len   = win_idx ? len1 : len0;
    assign cur_oh    = cur_idx ? 2'b10 : 2'b01;
    assign cur_wdata = cur_idx ? wdata1 : wdata0;
    assign last_beat = (beat_cnt == cur_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bus_dir  <= DIR_RD;
            rr_ptr   <= 1'b0;
            cur_idx  <= 1'b0;
            cur_wr   <= DIR_RD;
            cur_len  <= '0;
            beat_cnt <= '0;
            turn_cnt <= '0;
            rvalid   <= 2'b00;
            rdata    <= 8'h00;
            uio_out  <= 8'h00;
            uio_oe   <= 8'h00;
        end else begin
            rvalid <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        cur_idx  <= win_idx;
                        cur_wr   <= sel_wr;
                        cur_len  <= sel_len;
                        beat_cnt <= '0;
                        turn_cnt <= '0;
                        if (sel_wr == bus_dir) begin
                            state <= ST_XFER;
                        end else begin
                            state  <= ST_TURN;
                            uio_oe <= 8'h00;
                        end
                    end
                end
                ST_TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        bus_dir <= cur_wr;
                        state   <= ST_XFER;
                    end else begin
                        turn_cnt <= turn_cnt + 2'd1;
                    end
                end
                ST_XFER: begin
                    if (cur_wr) begin
                        uio_out <= cur_wdata;
                        uio_oe  <= 8'hFF;
                    end else begin
                        rdata  <= uio_in;
                        rvalid <= cur_oh;
                    end
                    if (last_beat) begin
                        rr_ptr <= ~cur_idx;
                        state  <= ST_IDLE;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        gnt   = 2'b00;
        wbeat = 2'b00;
        done  = 2'b00;
        if (state != ST_IDLE) begin
            gnt = cur_oh;
        end
        if (state == ST_XFER) begin
            if (cur_wr) begin
                wbeat = cur_oh;
            end
            if (last_beat) begin
                done = cur_oh;
            end
        end
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter: a per-cycle table of inputs and expected
// outputs, followed by a hand-written mid-burst reset sequence.
module tb_uio_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req, wr;
    logic [3:0] len0, len1;
    logic [7:0] wdata0, wdata1, uio_in;
    logic [1:0] gnt, wbeat, rvalid, done, state_dbg;
    logic [7:0] rdata, uio_out, uio_oe;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [1:0] req, wr;
        logic [3:0] len0, len1;
        logic [7:0] wd0, wd1, uin;
        logic [1:0] e_gnt, e_wbeat, e_rvalid, e_done;
        logic       e_busy;
        logic [7:0] e_rdata, e_out, e_oe;
    } vec_t;

    vec_t vecs[$];

    uio_bus_arbiter #(.TURN_CYCLES(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .wr        (wr),
        .len0      (len0),
        .len1      (len1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .uio_in    (uio_in),
        .gnt       (gnt),
        .wbeat     (wbeat),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .done      (done),
        .uio_out   (uio_out),
        .uio_oe    (uio_oe),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic r, input logic [1:0] rq, input logic [1:0] w,
        input logic [3:0] l0, input logic [3:0] l1,
        input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] ui,
        input logic [1:0] g, input logic [1:0] wb, input logic [1:0] rv,
        input logic [1:0] dn, input logic bz,
        input logic [7:0] rd, input logic [7:0] uo, input logic [7:0] oe);
        vec_t v;
        v.rst = r; v.req = rq; v.wr = w; v.len0 = l0; v.len1 = l1;
        v.wd0 = d0; v.wd1 = d1; v.uin = ui;
        v.e_gnt = g; v.e_wbeat = wb; v.e_rvalid = rv; v.e_done = dn;
        v.e_busy = bz; v.e_rdata = rd; v.e_out = uo; v.e_oe = oe;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got=%02h expected=%02h", name, idx, act, exp);
        end
    endtask

    // Drives one cycle's inputs just after a rising edge, checks mid-cycle,
    // then moves on to just after the next rising edge.
    task automatic run_vec(input vec_t v, input int idx);
        rst = v.rst; req = v.req; wr = v.wr; len0 = v.len0; len1 = v.len1;
        wdata0 = v.wd0; wdata1 = v.wd1; uio_in = v.uin;
        @(negedge clk);
        chk("gnt",    idx, {6'b0, gnt},    {6'b0, v.e_gnt});
        chk("wbeat",  idx, {6'b0, wbeat},  {6'b0, v.e_wbeat});
        chk("rvalid", idx, {6'b0, rvalid}, {6'b0, v.e_rvalid});
        chk("done",   idx, {6'b0, done},   {6'b0, v.e_done});
        chk("busy",   idx, {7'b0, busy},   {7'b0, v.e_busy});
        chk("rdata",  idx, rdata,   v.e_rdata);
        chk("uio_out", idx, uio_out, v.e_out);
        chk("uio_oe", idx, uio_oe,  v.e_oe);
        chk("gnt_onehot", idx, {7'b0, ($countones(gnt) <= 1)}, 8'h01);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; wr = 2'b00; len0 = 4'h0; len1 = 4'h0;
        wdata0 = 8'h00; wdata1 = 8'h00; uio_in = 8'h00;

        // rst     req    wr     l0 l1 wd0    wd1    uin     gnt    wbeat  rvalid done   bz rdata  uio_out oe
        vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 8'h00, 8'h00, 8'h00));
        // write after reset: TURN, three beats, pins park as outputs
        vecs.push_back(mk(0, 2'b01, 2'b01, 2, 0, 8'hA1, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(0, 2'b01, 2'b01, 2, 0, 8'hA1, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(0, 2'b01, 2'b01, 2, 0, 8'hA1, 8'h00, 8'h00, 2'b01, 2'b01, 2'b00, 2'b00, 1, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(0, 2'b01, 2'b01, 2, 0, 8'hA2, 8'h00, 8'h00, 2'b01, 2'b01, 2'b00, 2'b00, 1, 8'h00, 8'hA1, 8'hFF));
        vecs.push_back(mk(0, 2'b01, 2'b01, 2, 0, 8'hA3, 8'h00, 8'h00, 2'b01, 2'b01, 2'b00, 2'b01, 1, 8'h00, 8'hA2, 8'hFF));
        vecs.push_back(mk(0, 2'b00, 2'b01, 2, 0, 8'hA3, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 8'h00, 8'hA3, 8'hFF));
        vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 8'h00, 8'hA3, 8'hFF));
        // simultaneous single-beat reads, requester 0 first, no TURN
        vecs.push_back(mk(0, 2'b11, 2'b00, 0, 0, 8'h00, 8'h00, 8'h5A, 2'b00, 2'b00, 2'b00, 2'b00, 0, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(0, 2'b11, 2'b00, 0, 0, 8'h00, 8'h00, 8'h5A, 2'b01, 2'b00, 2'b00, 2'b01, 1, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(0, 2'b10, 2'b00, 0, 0, 8'h00, 8'h00, 8'hC3, 2'b00, 2'b00, 2'b01, 2'b00, 0, 8'h5A, 8'h00, 8'h00));
        vecs.push_back(mk(0, 2'b10, 2'b00, 0, 0, 8'h00, 8'h00, 8'hC3, 2'b10, 2'b00, 2'b00, 2'b10, 1, 8'h5A, 8'h00, 8'h00));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10, 2'b00, 0, 8'hC3, 8'h00, 8'h00));
        // write by requester 0, then a two-beat read by requester 1
        vecs.push_back(mk(0, 2'b01, 2'b01, 0, 0, 8'hB4, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 8'hC3, 8'h00, 8'h00));
        vecs.push_back(mk(0, 2'b01, 2'b01, 0, 0, 8'hB4, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 8'hC3, 8'h00, 8'h00));
        vecs.push_back(mk(0, 2'b01, 2'b01, 0, 0, 8'hB4, 8'h00, 8'h00, 2'b01, 2'b01, 2'b00, 2'b01, 1, 8'hC3, 8'h00, 8'h00));
        vecs.push_back(mk(0, 2'b10, 2'b00, 0, 1, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 8'hC3, 8'hB4, 8'hFF));
        vecs.push_back(mk(0, 2'b10, 2'b00, 0, 1, 8'h00, 8'h00, 8'h66, 2'b10, 2'b00, 2'b00, 2'b00, 1, 8'hC3, 8'hB4, 8'h00));
        vecs.push_back(mk(0, 2'b10, 2'b00, 0, 1, 8'h00, 8'h00, 8'h66, 2'b10, 2'b00, 2'b00, 2'b00, 1, 8'hC3, 8'hB4, 8'h00));
        vecs.push_back(mk(0, 2'b10, 2'b00, 0, 1, 8'h00, 8'h00, 8'h77, 2'b10, 2'b00, 2'b10, 2'b10, 1, 8'h66, 8'hB4, 8'h00));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10, 2'b00, 0, 8'h77, 8'hB4, 8'h00));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 8'h77, 8'hB4, 8'h00));
        // fairness: requester 0 re-requests right after done while 1 waits
        vecs.push_back(mk(0, 2'b11, 2'b00, 0, 0, 8'h00, 8'h00, 8'h11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 8'h77, 8'hB4, 8'h00));
        vecs.push_back(mk(0, 2'b11, 2'b00, 0, 0, 8'h00, 8'h00, 8'h11, 2'b01, 2'b00, 2'b00, 2'b01, 1, 8'h77, 8'hB4, 8'h00));
        vecs.push_back(mk(0, 2'b11, 2'b00, 0, 0, 8'h00, 8'h00, 8'h22, 2'b00, 2'b00, 2'b01, 2'b00, 0, 8'h11, 8'hB4, 8'h00));
        vecs.push_back(mk(0, 2'b11, 2'b00, 0, 0, 8'h00, 8'h00, 8'h22, 2'b10, 2'b00, 2'b00, 2'b10, 1, 8'h11, 8'hB4, 8'h00));
        vecs.push_back(mk(0, 2'b01, 2'b00, 0, 0, 8'h00, 8'h00, 8'h33, 2'b00, 2'b00, 2'b10, 2'b00, 0, 8'h22, 8'hB4, 8'h00));
        vecs.push_back(mk(0, 2'b01, 2'b00, 0, 0, 8'h00, 8'h00, 8'h33, 2'b01, 2'b00, 2'b00, 2'b01, 1, 8'h22, 8'hB4, 8'h00));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b01, 2'b00, 0, 8'h33, 8'hB4, 8'h00));

        // two reset edges before the table starts
        @(posedge clk); #1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_vec(vecs[i], i);
        end

        // Mid-burst reset: len=7 write, rst raised in the second XFER cycle.
        run_vec(mk(0, 2'b01, 2'b01, 7, 0, 8'hD1, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 8'h33, 8'hB4, 8'h00), 100);
        rst = 1'b0; req = 2'b01; wr = 2'b01; len0 = 4'd7; wdata0 = 8'hD1;
        @(negedge clk);
        chk("state_turn", 101, {6'b0, state_dbg}, 8'h01);
        @(posedge clk); #1;
        run_vec(mk(0, 2'b01, 2'b01, 7, 0, 8'hD1, 8'h00, 8'h00, 2'b01, 2'b01, 2'b00, 2'b00, 1, 8'h33, 8'hB4, 8'h00), 102);
        run_vec(mk(1, 2'b01, 2'b01, 7, 0, 8'hD2, 8'h00, 8'h00, 2'b01, 2'b01, 2'b00, 2'b00, 1, 8'h33, 8'hD1, 8'hFF), 103);
        run_vec(mk(0, 2'b00, 2'b00, 0, 0, 8'hD3, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 8'h00, 8'h00, 8'h00), 104);
        run_vec(mk(0, 2'b00, 2'b00, 0, 0, 8'hD4, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 8'h00, 8'h00, 8'h00), 105);
        // bus_dir back at read after reset: a read goes straight to XFER
        run_vec(mk(0, 2'b01, 2'b00, 0, 0, 8'h00, 8'h00, 8'h9C, 2'b00, 2'b00, 2'b00, 2'b00, 0, 8'h00, 8'h00, 8'h00), 106);
        run_vec(mk(0, 2'b01, 2'b00, 0, 0, 8'h00, 8'h00, 8'h9C, 2'b01, 2'b00, 2'b00, 2'b01, 1, 8'h00, 8'h00, 8'h00), 107);
        run_vec(mk(0, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b01, 2'b00, 0, 8'h9C, 8'h00, 8'h00), 108);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
